multicycle_maindec: RTL and testbench

- Multicycle successor to the single-cycle main decoder: a Moore FSM that sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK for the same instruction set (R-type, lw, sw, beq, bne, addi, andi, ori, slti, j).
- Adds a memory-ready handshake with optional stall, an illegal-opcode trap, and parametrised field widths.
- Sits between the instruction register and the multicycle datapath; the existing ALU decoder still consumes aluop.

---
 rtl/multicycle_maindec_pkg.sv | 85 ++++++++
 rtl/multicycle_maindec_if.sv | 40 ++++
 rtl/multicycle_maindec_outdec.sv | 93 +++++++++
 rtl/multicycle_maindec.sv | 105 ++++++++++
 tb/tb_multicycle_maindec.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_maindec_pkg.sv
// Shared definitions for the multicycle main decoder.
// Holds the state encoding, opcode values, datapath select encodings and
// the packed control bundle carried from the output decoder to the top.
package mips_ctrl_pkg;

  localparam int unsigned OPC_W     = 6;
  localparam int unsigned ALUOP_BITS = 3;
  localparam int unsigned STATE_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    IEXE    = 4'd9,
    IWB     = 4'd10,
    JUMP    = 4'd11,
    TRAP    = 4'd12
  } state_t;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_BITS-1:0] ALUOP_ADD   = 3'b000;
  localparam logic [ALUOP_BITS-1:0] ALUOP_SUB   = 3'b001;
  localparam logic [ALUOP_BITS-1:0] ALUOP_FUNCT = 3'b010;
  localparam logic [ALUOP_BITS-1:0] ALUOP_AND   = 3'b011;
  localparam logic [ALUOP_BITS-1:0] ALUOP_OR    = 3'b100;
  localparam logic [ALUOP_BITS-1:0] ALUOP_SLT   = 3'b101;

  localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic                  pcwrite;
    logic                  irwrite;
    logic                  regwrite;
    logic                  memwrite;
    logic                  iord;
    logic                  alusrca;
    logic                  regdst;
    logic                  memtoreg;
    logic                  branch;
    logic                  branchne;
    logic [1:0]            alusrcb;
    logic [1:0]            pcsrc;
    logic [ALUOP_BITS-1:0] aluop;
    logic                  sig;
    logic                  illegal;
  } ctrl_t;

  // Clear every write/branch/trap strobe, leaving mux selects untouched.
  function automatic ctrl_t gate_strobes(input ctrl_t c);
    ctrl_t g;
    g          = c;
    g.pcwrite  = 1'b0;
    g.irwrite  = 1'b0;
    g.regwrite = 1'b0;
    g.memwrite = 1'b0;
    g.branch   = 1'b0;
    g.branchne = 1'b0;
    g.illegal  = 1'b0;
    return g;
  endfunction

endpackage

// File: rtl/multicycle_maindec_if.sv
// Control bus between the instruction register / memory and the datapath.
// master: decoder side (consumes op, mem_ready; drives all controls).
// slave : datapath side (the mirror image).
interface multicycle_maindec_if #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 3
);
  logic [OP_W-1:0]    op;
  logic               mem_ready;
  logic               pcwrite;
  logic               irwrite;
  logic               regwrite;
  logic               memwrite;
  logic               iord;
  logic               alusrca;
  logic               regdst;
  logic               memtoreg;
  logic               branch;
  logic               branchne;
  logic [1:0]         alusrcb;
  logic [1:0]         pcsrc;
  logic [ALUOP_W-1:0] aluop;
  logic               sig;
  logic               illegal;
  logic [3:0]         state_o;

  modport master (
    input  op, mem_ready,
    output pcwrite, irwrite, regwrite, memwrite, iord, alusrca, regdst,
           memtoreg, branch, branchne, alusrcb, pcsrc, aluop, sig, illegal,
           state_o
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, irwrite, regwrite, memwrite, iord, alusrca, regdst,
           memtoreg, branch, branchne, alusrcb, pcsrc, aluop, sig, illegal,
           state_o
  );
endinterface

// File: rtl/multicycle_maindec_outdec.sv
// mc_outdec: combinational map from (state, latched opcode, memory ready)
// to the control bundle.
// Ports: state  - current FSM state
//        op_q   - opcode latched during DECODE
//        ready  - effective memory-ready (already forced high if unused)
//        ctrl_c - control bundle, unlisted fields 0
module mc_outdec
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OP_W = 6
) (
  input  state_t          state,
  input  logic [OP_W-1:0] op_q,
  input  logic            ready,
  output ctrl_t           ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    case (state)
      FETCH: begin
        ctrl_c.alusrcb = ALUSRCB_FOUR;
        ctrl_c.aluop   = ALUOP_ADD;
        ctrl_c.pcsrc   = PCSRC_ALU;
        ctrl_c.irwrite = ready;
        ctrl_c.pcwrite = ready;
      end
      DECODE: begin
        ctrl_c.alusrcb = ALUSRCB_IMMSH;
        ctrl_c.aluop   = ALUOP_ADD;
        ctrl_c.sig     = 1'b1;
      end
      MEMADR: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.alusrcb = ALUSRCB_IMM;
        ctrl_c.aluop   = ALUOP_ADD;
        ctrl_c.sig     = 1'b1;
      end
      MEMRD: ctrl_c.iord = 1'b1;
      MEMWB: begin
        ctrl_c.memtoreg = 1'b1;
        ctrl_c.regwrite = 1'b1;
      end
      // memwrite stays asserted for every cycle the access is stalled
      MEMWR: begin
        ctrl_c.iord     = 1'b1;
        ctrl_c.memwrite = 1'b1;
      end
      RTYPEEX: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.alusrcb = ALUSRCB_REGB;
        ctrl_c.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl_c.regdst   = 1'b1;
        ctrl_c.regwrite = 1'b1;
      end
      BRANCH: begin
        ctrl_c.alusrca  = 1'b1;
        ctrl_c.alusrcb  = ALUSRCB_REGB;
        ctrl_c.aluop    = ALUOP_SUB;
        ctrl_c.pcsrc    = PCSRC_ALUOUT;
        ctrl_c.branch   = (op_q == OP_W'(OP_BEQ));
        ctrl_c.branchne = (op_q == OP_W'(OP_BNE));
      end
      IEXE: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.alusrcb = ALUSRCB_IMM;
        if (op_q == OP_W'(OP_ANDI)) begin
          ctrl_c.aluop = ALUOP_AND;
          ctrl_c.sig   = 1'b0;
        end else if (op_q == OP_W'(OP_ORI)) begin
          ctrl_c.aluop = ALUOP_OR;
          ctrl_c.sig   = 1'b0;
        end else if (op_q == OP_W'(OP_SLTI)) begin
          ctrl_c.aluop = ALUOP_SLT;
          ctrl_c.sig   = 1'b1;
        end else begin
          ctrl_c.aluop = ALUOP_ADD;
          ctrl_c.sig   = 1'b1;
        end
      end
      IWB: ctrl_c.regwrite = 1'b1;
      JUMP: begin
        ctrl_c.pcsrc   = PCSRC_JUMP;
        ctrl_c.pcwrite = 1'b1;
      end
      TRAP: ctrl_c.illegal = 1'b1;
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_maindec.sv
// Multicycle main decoder: Moore FSM sequencing fetch/decode/execute/
// memory/writeback for the supported instruction set.
// Ports: clk, reset (synchronous, active-high)
//        bus - multicycle_maindec_if.master: op and mem_ready in, all
//              datapath strobes/selects, aluop, illegal and state_o out.
module multicycle_maindec
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OP_W          = 6,
  parameter int unsigned ALUOP_W       = 3,
  parameter bit          MEM_HANDSHAKE = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_maindec_if.master bus
);

  state_t          state_q;
  state_t          state_d;
  state_t          out_state;
  logic [OP_W-1:0] op_q;
  logic            ready;
  ctrl_t           ctrl_c;
  ctrl_t           ctrl_g;

  assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  // State register and opcode latch (op captured on the DECODE cycle only).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= bus.op;
    end
  end

  // Next-state logic; DECODE looks at the live opcode, later states at op_q.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = ready ? DECODE : FETCH;
      DECODE: begin
        if (bus.op == OP_W'(OP_LW) || bus.op == OP_W'(OP_SW))
          state_d = MEMADR;
        else if (bus.op == OP_W'(OP_RTYPE))
          state_d = RTYPEEX;
        else if (bus.op == OP_W'(OP_BEQ) || bus.op == OP_W'(OP_BNE))
          state_d = BRANCH;
        else if (bus.op == OP_W'(OP_ADDI) || bus.op == OP_W'(OP_ANDI) ||
                 bus.op == OP_W'(OP_ORI)  || bus.op == OP_W'(OP_SLTI))
          state_d = IEXE;
        else if (bus.op == OP_W'(OP_J))
          state_d = JUMP;
        else
          state_d = TRAP;
      end
      MEMADR:  state_d = (op_q == OP_W'(OP_SW)) ? MEMWR : MEMRD;
      MEMRD:   state_d = ready ? MEMWB : MEMRD;
      MEMWB:   state_d = FETCH;
      MEMWR:   state_d = ready ? FETCH : MEMWR;
      RTYPEEX: state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      IEXE:    state_d = IWB;
      IWB:     state_d = FETCH;
      JUMP:    state_d = FETCH;
      TRAP:    state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // During reset present FETCH selects with every strobe suppressed.
  assign out_state = reset ? FETCH : state_q;

  mc_outdec #(
    .OP_W (OP_W)
  ) u_outdec (
    .state  (out_state),
    .op_q   (op_q),
    .ready  (ready),
    .ctrl_c (ctrl_c)
  );

  assign ctrl_g = reset ? gate_strobes(ctrl_c) : ctrl_c;

  assign bus.pcwrite  = ctrl_g.pcwrite;
  assign bus.irwrite  = ctrl_g.irwrite;
  assign bus.regwrite = ctrl_g.regwrite;
  assign bus.memwrite = ctrl_g.memwrite;
  assign bus.iord     = ctrl_g.iord;
  assign bus.alusrca  = ctrl_g.alusrca;
  assign bus.regdst   = ctrl_g.regdst;
  assign bus.memtoreg = ctrl_g.memtoreg;
  assign bus.branch   = ctrl_g.branch;
  assign bus.branchne = ctrl_g.branchne;
  assign bus.alusrcb  = ctrl_g.alusrcb;
  assign bus.pcsrc    = ctrl_g.pcsrc;
  assign bus.aluop    = ALUOP_W'(ctrl_g.aluop);
  assign bus.sig      = ctrl_g.sig;
  assign bus.illegal  = ctrl_g.illegal;
  assign bus.state_o  = 4'(state_q);

endmodule

// File: tb/tb_multicycle_maindec.sv
// Self-checking bench for multicycle_maindec: directed scenarios followed by
// randomized instruction streams, compared against a trace-level reference.
module tb_multicycle_maindec;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                 S_MEMWB = 4, S_MEMWR = 5, S_RTYPEEX = 6, S_ALUWB = 7,
                 S_BRANCH = 8, S_IEXE = 9, S_IWB = 10, S_JUMP = 11,
                 S_TRAP = 12;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  multicycle_maindec_if #(.OP_W(6), .ALUOP_W(3)) bus ();

  multicycle_maindec #(
    .OP_W          (6),
    .ALUOP_W       (3),
    .MEM_HANDSHAKE (1'b1)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected control vector, ordered:
  // pcwrite irwrite regwrite memwrite iord alusrca regdst memtoreg branch
  // branchne alusrcb[2] pcsrc[2] aluop[3] sig illegal
  function automatic logic [18:0] exp_vec(input int st, input logic [5:0] opc, input bit rdy);
    logic pcw, irw, rw, mw, io, asa, rd, m2r, br, bn, sg, il;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    pcw = 0; irw = 0; rw = 0; mw = 0; io = 0; asa = 0; rd = 0; m2r = 0;
    br = 0; bn = 0; sg = 0; il = 0; asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      S_FETCH:   begin asb = 2'b01; pcw = rdy; irw = rdy; end
      S_DECODE:  begin asb = 2'b11; sg = 1; end
      S_MEMADR:  begin asa = 1; asb = 2'b10; sg = 1; end
      S_MEMRD:   io = 1;
      S_MEMWB:   begin m2r = 1; rw = 1; end
      S_MEMWR:   begin io = 1; mw = 1; end
      S_RTYPEEX: begin asa = 1; aop = 3'b010; end
      S_ALUWB:   begin rd = 1; rw = 1; end
      S_BRANCH:  begin
        asa = 1; aop = 3'b001; pcs = 2'b01;
        br = (opc == 6'b000100); bn = (opc == 6'b000101);
      end
      S_IEXE: begin
        asa = 1; asb = 2'b10;
        case (opc)
          6'b001100: begin aop = 3'b011; sg = 0; end
          6'b001101: begin aop = 3'b100; sg = 0; end
          6'b001010: begin aop = 3'b101; sg = 1; end
          default:   begin aop = 3'b000; sg = 1; end
        endcase
      end
      S_IWB:  rw = 1;
      S_JUMP: begin pcs = 2'b10; pcw = 1; end
      S_TRAP: il = 1;
      default: ;
    endcase
    return {pcw, irw, rw, mw, io, asa, rd, m2r, br, bn, asb, pcs, aop, sg, il};
  endfunction

  function automatic logic [18:0] obs_vec();
    return {bus.pcwrite, bus.irwrite, bus.regwrite, bus.memwrite, bus.iord,
            bus.alusrca, bus.regdst, bus.memtoreg, bus.branch, bus.branchne,
            bus.alusrcb, bus.pcsrc, bus.aluop, bus.sig, bus.illegal};
  endfunction

  // Instruction class: 0 lw, 1 sw, 2 R, 3 I-ALU, 4 branch, 5 j, 6 illegal.
  function automatic int op_class(input logic [5:0] opc);
    case (opc)
      6'b100011: return 0;
      6'b101011: return 1;
      6'b000000: return 2;
      6'b001000, 6'b001100, 6'b001101, 6'b001010: return 3;
      6'b000100, 6'b000101: return 4;
      6'b000010: return 5;
      default: return 6;
    endcase
  endfunction

  // Run one instruction: fstall FETCH wait cycles, mstall memory wait cycles.
  // scr selects what op does after DECODE (0 hold, 1 all ones, 2 random).
  // rst_at >= 0 asserts reset in that cycle of the trace and ends it there.
  task automatic run_instr(input logic [5:0] opc, input int fstall, input int mstall,
                           input int scr, input int rst_at, input string tag);
    int ph[$];
    bit rq[$];
    int dec_idx;
    int cls;
    cls = op_class(opc);
    for (int i = 0; i < fstall; i++) begin ph.push_back(S_FETCH); rq.push_back(1'b0); end
    ph.push_back(S_FETCH); rq.push_back(1'b1);
    dec_idx = ph.size();
    ph.push_back(S_DECODE); rq.push_back(1'($urandom));
    case (cls)
      0, 1: begin
        ph.push_back(S_MEMADR); rq.push_back(1'($urandom));
        for (int i = 0; i < mstall; i++) begin
          ph.push_back(cls == 0 ? S_MEMRD : S_MEMWR); rq.push_back(1'b0);
        end
        ph.push_back(cls == 0 ? S_MEMRD : S_MEMWR); rq.push_back(1'b1);
        if (cls == 0) begin ph.push_back(S_MEMWB); rq.push_back(1'($urandom)); end
      end
      2: begin
        ph.push_back(S_RTYPEEX); rq.push_back(1'($urandom));
        ph.push_back(S_ALUWB);   rq.push_back(1'($urandom));
      end
      3: begin
        ph.push_back(S_IEXE); rq.push_back(1'($urandom));
        ph.push_back(S_IWB);  rq.push_back(1'($urandom));
      end
      4: begin ph.push_back(S_BRANCH); rq.push_back(1'($urandom)); end
      5: begin ph.push_back(S_JUMP);   rq.push_back(1'($urandom)); end
      default: begin ph.push_back(S_TRAP); rq.push_back(1'($urandom)); end
    endcase

    for (int k = 0; k < ph.size(); k++) begin
      if (k < dec_idx)       bus.op = 6'($urandom);
      else if (k == dec_idx) bus.op = opc;
      else if (scr == 1)     bus.op = 6'b111111;
      else if (scr == 2)     bus.op = 6'($urandom);
      else                   bus.op = opc;
      bus.mem_ready = rq[k];
      if (k == rst_at) begin
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        check({tag, "_rst_state_in"}, 32'(bus.state_o), 32'(ph[k]));
        check({tag, "_rst_regwrite"}, 32'(bus.regwrite), 32'd0);
        check({tag, "_rst_ctrl"}, 32'(obs_vec()), 32'(exp_vec(S_FETCH, opc, 1'b0)));
        @(posedge clk); #1;
        reset = 1'b0;
        check({tag, "_rst_next_state"}, 32'(bus.state_o), 32'(S_FETCH));
        return;
      end
      #1;
      check({tag, "_state"}, 32'(bus.state_o), 32'(ph[k]));
      check({tag, "_ctrl"}, 32'(obs_vec()), 32'(exp_vec(ph[k], opc, rq[k])));
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    check({tag, "_back_to_fetch"}, 32'(bus.state_o), 32'(S_FETCH));
  endtask

  logic [5:0] legal_ops [10];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                  6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010};

    // Reset: FETCH selects with strobes held low even though memory is ready.
    reset = 1'b1;
    bus.op = 6'b000000;
    bus.mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    #1;
    check("reset_state", 32'(bus.state_o), 32'(S_FETCH));
    check("reset_ctrl", 32'(obs_vec()), 32'(exp_vec(S_FETCH, 6'b0, 1'b0)));
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(6'b000000, 0, 0, 0, -1, "rtype");
    run_instr(6'b100011, 0, 2, 0, -1, "lw_stall2");
    run_instr(6'b101011, 0, 1, 0, -1, "sw_stall1");
    run_instr(6'b000100, 0, 0, 0, -1, "beq");
    run_instr(6'b000101, 0, 0, 0, -1, "bne");
    run_instr(6'b001100, 0, 0, 1, -1, "andi_scr");
    run_instr(6'b001101, 0, 0, 1, -1, "ori_scr");
    run_instr(6'b001010, 0, 0, 1, -1, "slti_scr");
    run_instr(6'b001000, 2, 0, 1, -1, "addi_fstall");
    run_instr(6'b000010, 0, 0, 2, -1, "jump");
    run_instr(6'b111111, 0, 0, 0, -1, "illegal");
    run_instr(6'b100011, 0, 0, 0, 4, "lw_rst_memwb");
    run_instr(6'b101011, 1, 3, 0, 5, "sw_rst_memwr");
    run_instr(6'b000000, 0, 0, 0, 2, "rtype_rst_exec");

    // Randomized stream, occasionally with an arbitrary (often illegal) opcode.
    for (int n = 0; n < 120; n++) begin
      logic [5:0] opc;
      if ($urandom_range(7) == 0) opc = 6'($urandom);
      else opc = legal_ops[$urandom_range(9)];
      run_instr(opc, int'($urandom_range(2)), int'($urandom_range(3)),
                int'($urandom_range(2)), -1, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
